// File: rtl/uart_load_ctrl_pkg.sv
// Shared definitions for the UART ROM-load sequencer: command codes,
// sequencer state encoding and default geometry.
package uart_load_pkg;

  // Command codes carried on the demux channel byte.
  localparam logic [7:0] CMD_START    = 8'h00;
  localparam logic [7:0] CMD_SET_ADDR = 8'h01;
  localparam logic [7:0] CMD_DATA     = 8'h02;
  localparam logic [7:0] CMD_END      = 8'h03;

  // Default geometry of the load path.
  localparam int DEFAULT_ADDR_W     = 22;
  localparam int DEFAULT_FIFO_DEPTH = 16;

  // Sequencer states.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } load_state_t;

endpackage

// File: rtl/uart_load_ctrl_if.sv
// Bus bundle between the packet demux / memory write port (master side)
// and the load sequencer (slave side).
interface uart_load_ctrl_if
  import uart_load_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W
);
  // Demux stream
  logic [7:0]        i_addr;
  logic [7:0]        i_data;
  logic              i_write;
  logic              i_checksum_error;
  // Memory write port
  logic [ADDR_W-1:0] o_mem_addr;
  logic [7:0]        o_mem_data;
  logic              o_mem_req;
  logic              i_mem_ack;

  modport slave (
    input  i_addr, i_data, i_write, i_checksum_error, i_mem_ack,
    output o_mem_addr, o_mem_data, o_mem_req
  );

  modport master (
    output i_addr, i_data, i_write, i_checksum_error, i_mem_ack,
    input  o_mem_addr, o_mem_data, o_mem_req
  );
endinterface

// File: rtl/uart_load_ctrl_load_fifo.sv
// Small synchronous FIFO holding tagged {address, byte} entries between
// the command decoder and the memory write port. Flush beats push and pop;
// a push while full is dropped.
module load_fifo #(
  parameter int WIDTH = 30,
  parameter int DEPTH = 16,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             i_Clock,
  input  logic             RESET,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == {CNT_W{1'b0}});
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];

  // Next pointer/occupancy; flush clears everything regardless of push/pop.
  always_comb begin
    push_ok  = push && !full && !flush;
    pop_ok   = pop && !empty && !flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = {PTR_W{1'b0}};
      rd_ptr_d = {PTR_W{1'b0}};
      count_d  = {CNT_W{1'b0}};
    end else begin
      if (push_ok) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1'b1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1'b1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CNT_W'(1'b1);
        2'b01:   count_d = count_q - CNT_W'(1'b1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge i_Clock) begin
    if (RESET) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents need no reset because occupancy gates reads.
  always_ff @(posedge i_Clock) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/uart_load_ctrl.sv
// ROM-load sequencer: decodes demux commands into tagged bytes, queues them,
// writes them out over a req/ack port, and holds the core in reset meanwhile.
module uart_load_ctrl
  import uart_load_pkg::*;
#(
  parameter int ADDR_W     = DEFAULT_ADDR_W,
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic             i_Clock,
  input  logic             RESET,
  uart_load_ctrl_if.slave  bus,
  output logic             o_core_reset,
  output logic             o_loading,
  output logic             o_done,
  output logic             o_error
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int ENT_W = ADDR_W + 8;

  load_state_t       state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              core_reset_q, core_reset_d;
  logic              loading_q, loading_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic              chk_q, chk_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_data_q, mem_data_d;

  logic              start_cmd, set_addr_cmd, data_cmd, end_cmd;
  logic              chk_rise;
  logic              fifo_push, fifo_pop, fifo_flush;
  logic              fifo_full, fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic [ENT_W-1:0]  fifo_rd_data;

  assign start_cmd    = bus.i_write && (bus.i_addr == CMD_START);
  assign set_addr_cmd = bus.i_write && (bus.i_addr == CMD_SET_ADDR);
  assign data_cmd     = bus.i_write && (bus.i_addr == CMD_DATA);
  assign end_cmd      = bus.i_write && (bus.i_addr == CMD_END);
  assign chk_rise     = bus.i_checksum_error && !chk_q;

  load_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_Clock   (i_Clock),
    .RESET     (RESET),
    .push      (fifo_push),
    .push_data ({ptr_q, bus.i_data}),
    .pop       (fifo_pop),
    .flush     (fifo_flush),
    .pop_data  (fifo_rd_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Command decode and sequencer state; START overrides everything else.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    core_reset_d = core_reset_q;
    done_d       = done_q;
    error_d      = error_q;
    fifo_push    = 1'b0;
    fifo_flush   = 1'b0;
    chk_d        = bus.i_checksum_error;

    case (state_q)
      S_IDLE: begin
        state_d = S_IDLE;
      end
      S_LOAD: begin
        if (set_addr_cmd) begin
          ptr_d = {ptr_q[ADDR_W-9:0], bus.i_data};
        end else if (data_cmd) begin
          // A byte arriving at full is lost, but its address slot is still consumed.
          fifo_push = 1'b1;
          ptr_d     = ptr_q + ADDR_W'(1'b1);
          if (fifo_full) begin
            error_d = 1'b1;
          end else begin
            error_d = error_q;
          end
        end else if (end_cmd) begin
          state_d = S_DRAIN;
        end else begin
          state_d = S_LOAD;
        end
      end
      S_DRAIN: begin
        if ((fifo_count == {CNT_W{1'b0}}) && !req_q) begin
          state_d      = S_DONE;
          done_d       = 1'b1;
          core_reset_d = 1'b0;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (start_cmd) begin
      state_d      = S_LOAD;
      ptr_d        = {ADDR_W{1'b0}};
      fifo_push    = 1'b0;
      fifo_flush   = 1'b1;
      core_reset_d = 1'b1;
      done_d       = 1'b0;
      error_d      = 1'b0;
    end else begin
      fifo_flush = 1'b0;
    end

    // Checksum trouble is recorded even in the cycle a START clears the flag.
    if (chk_rise) begin
      error_d = 1'b1;
    end else begin
      error_d = error_d;
    end

    loading_d = (state_d == S_LOAD) || (state_d == S_DRAIN);
  end

  // Memory handshake: present one entry, hold it until acked, then idle a cycle.
  always_comb begin
    req_d      = req_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    fifo_pop   = 1'b0;
    if (req_q) begin
      if (bus.i_mem_ack) begin
        req_d = 1'b0;
      end else begin
        req_d = 1'b1;
      end
    end else if (!fifo_empty && !fifo_flush) begin
      fifo_pop   = 1'b1;
      req_d      = 1'b1;
      mem_addr_d = fifo_rd_data[ENT_W-1:8];
      mem_data_d = fifo_rd_data[7:0];
    end else begin
      req_d = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge i_Clock) begin
    if (RESET) begin
      state_q      <= S_IDLE;
      ptr_q        <= {ADDR_W{1'b0}};
      core_reset_q <= 1'b0;
      loading_q    <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      chk_q        <= 1'b0;
      req_q        <= 1'b0;
      mem_addr_q   <= {ADDR_W{1'b0}};
      mem_data_q   <= 8'h00;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      core_reset_q <= core_reset_d;
      loading_q    <= loading_d;
      done_q       <= done_d;
      error_q      <= error_d;
      chk_q        <= chk_d;
      req_q        <= req_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
    end
  end

  assign bus.o_mem_req  = req_q;
  assign bus.o_mem_addr = mem_addr_q;
  assign bus.o_mem_data = mem_data_q;
  assign o_core_reset   = core_reset_q;
  assign o_loading      = loading_q;
  assign o_done         = done_q;
  assign o_error        = error_q;

endmodule

// File: tb/tb_uart_load_ctrl.sv
// Scoreboard bench for uart_load_ctrl: expected memory writes are queued as
// commands are issued; a negedge monitor acks requests and checks them.
module tb_uart_load_ctrl;
  import uart_load_pkg::*;

  localparam int AW    = 22;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0] drv_addr  = 8'h00;
  logic [7:0] drv_data  = 8'h00;
  logic       drv_write = 1'b0;
  logic       drv_chk   = 1'b0;
  logic       ack_r     = 1'b0;

  logic core_reset, loading, done, error;

  uart_load_ctrl_if #(.ADDR_W(AW)) bus();
  assign bus.i_addr           = drv_addr;
  assign bus.i_data           = drv_data;
  assign bus.i_write          = drv_write;
  assign bus.i_checksum_error = drv_chk;
  assign bus.i_mem_ack        = ack_r;

  uart_load_ctrl #(.ADDR_W(AW), .FIFO_DEPTH(DEPTH)) dut (
    .i_Clock      (clk),
    .RESET        (rst),
    .bus          (bus.slave),
    .o_core_reset (core_reset),
    .o_loading    (loading),
    .o_done       (done),
    .o_error      (error)
  );

  int tests = 0;
  int fails = 0;
  logic [AW+7:0] exp_q[$];
  bit  ack_en     = 1'b0;
  int  force_tok  = 0;
  int  force_seen = 0;
  int  wait_cnt   = 0;
  logic          prev_pend = 1'b0;
  logic [AW+7:0] prev_ent  = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [AW-1:0] a, input logic [7:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] d);
    drv_addr  = a;
    drv_data  = d;
    drv_write = 1'b1;
    @(negedge clk);
    drv_write = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check(name, {31'd0, done}, 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},  {31'd0, bus.o_mem_req}, 32'd0);
    check({tag, "_addr"}, {10'd0, bus.o_mem_addr}, 32'd0);
    check({tag, "_data"}, {24'd0, bus.o_mem_data}, 32'd0);
    check({tag, "_core_reset"}, {31'd0, core_reset}, 32'd0);
    check({tag, "_loading"}, {31'd0, loading}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_error"}, {31'd0, error}, 32'd0);
  endtask

  // Memory-port model and write monitor: acks one cycle after req is seen.
  always @(negedge clk) begin
    logic [AW+7:0] cur;
    cur = {bus.o_mem_addr, bus.o_mem_data};
    if (bus.o_mem_req && prev_pend) begin
      check("req_stable", {2'd0, cur}, {2'd0, prev_ent});
    end
    prev_pend = 1'b0;
    if (rst || ack_r) begin
      ack_r    = 1'b0;
      wait_cnt = 0;
    end else if (force_tok != force_seen) begin
      force_seen = force_tok;
      ack_r      = 1'b1;
    end else if (ack_en && bus.o_mem_req) begin
      if (wait_cnt >= 1) begin
        ack_r    = 1'b1;
        wait_cnt = 0;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_write: got 0x%0h expected none", cur);
        end else begin
          check("mem_write", {2'd0, cur}, {2'd0, exp_q.pop_front()});
        end
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
    if (bus.o_mem_req && !ack_r) begin
      prev_pend = 1'b1;
      prev_ent  = cur;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst = 1'b0;
    @(negedge clk);

    // Basic load with latency probe
    ack_en = 1'b1;
    send(CMD_START, 8'h00);
    check("start_core_reset", {31'd0, core_reset}, 32'd1);
    check("start_loading", {31'd0, loading}, 32'd1);
    send(CMD_SET_ADDR, 8'h00);
    send(CMD_SET_ADDR, 8'h10);
    send(CMD_SET_ADDR, 8'h00);
    push_exp(22'h001000, 8'hA5);
    send(CMD_DATA, 8'hA5);
    check("lat_n1_req", {31'd0, bus.o_mem_req}, 32'd0);
    @(negedge clk);
    check("lat_n2_req", {31'd0, bus.o_mem_req}, 32'd1);
    push_exp(22'h001001, 8'h5A);
    send(CMD_DATA, 8'h5A);
    send(CMD_END, 8'h00);
    check("drain_loading", {31'd0, loading}, 32'd1);
    wait_done("t1_done");
    check("t1_core_reset", {31'd0, core_reset}, 32'd0);
    check("t1_loading", {31'd0, loading}, 32'd0);
    check("t1_error", {31'd0, error}, 32'd0);

    // Address wrap
    send(CMD_START, 8'h00);
    check("t2_done_cleared", {31'd0, done}, 32'd0);
    send(CMD_SET_ADDR, 8'h3F);
    send(CMD_SET_ADDR, 8'hFF);
    send(CMD_SET_ADDR, 8'hFF);
    push_exp(22'h3FFFFF, 8'h11);
    send(CMD_DATA, 8'h11);
    push_exp(22'h000000, 8'h22);
    send(CMD_DATA, 8'h22);
    send(CMD_END, 8'h00);
    wait_done("t2_done");

    // Overflow with the port stalled: 17 fit, the 18th is dropped
    ack_en = 1'b0;
    send(CMD_START, 8'h00);
    send(CMD_SET_ADDR, 8'h00);
    send(CMD_SET_ADDR, 8'h20);
    send(CMD_SET_ADDR, 8'h00);
    for (int i = 0; i < 18; i++) begin
      if (i < 17) push_exp(22'h002000 + 22'(i), 8'h40 + 8'(i));
      send(CMD_DATA, 8'h40 + 8'(i));
      if (i == 16) check("t3_no_err_17", {31'd0, error}, 32'd0);
    end
    check("t3_ovf_err", {31'd0, error}, 32'd1);
    send(CMD_END, 8'h00);
    ack_en = 1'b1;
    wait_done("t3_done");
    check("t3_err_sticky", {31'd0, error}, 32'd1);

    // START while a request is outstanding
    ack_en = 1'b0;
    send(CMD_START, 8'h00);
    check("t4_done_cleared", {31'd0, done}, 32'd0);
    check("t4_err_cleared", {31'd0, error}, 32'd0);
    send(CMD_SET_ADDR, 8'h00);
    send(CMD_SET_ADDR, 8'h30);
    send(CMD_SET_ADDR, 8'h00);
    push_exp(22'h003000, 8'h01);
    send(CMD_DATA, 8'h01);
    send(CMD_DATA, 8'h02);
    send(CMD_DATA, 8'h03);
    drv_chk = 1'b1;
    @(negedge clk);
    check("t4_chk_err", {31'd0, error}, 32'd1);
    drv_chk = 1'b0;
    @(negedge clk);
    send(CMD_START, 8'h00);
    check("t4_req_held", {31'd0, bus.o_mem_req}, 32'd1);
    check("t4_addr_held", {10'd0, bus.o_mem_addr}, 32'h003000);
    check("t4_err_cleared2", {31'd0, error}, 32'd0);
    check("t4_core_reset", {31'd0, core_reset}, 32'd1);
    push_exp(22'h000000, 8'h44);
    send(CMD_DATA, 8'h44);
    send(CMD_END, 8'h00);
    ack_en = 1'b1;
    wait_done("t4_done");

    // Checksum error after END
    send(CMD_START, 8'h00);
    send(CMD_SET_ADDR, 8'h00);
    send(CMD_SET_ADDR, 8'h00);
    send(CMD_SET_ADDR, 8'h40);
    push_exp(22'h000040, 8'h77);
    send(CMD_DATA, 8'h77);
    send(CMD_END, 8'h00);
    drv_chk = 1'b1;
    @(negedge clk);
    check("t5_chk_err", {31'd0, error}, 32'd1);
    drv_chk = 1'b0;
    wait_done("t5_done");
    check("t5_err_sticky", {31'd0, error}, 32'd1);

    // RESET with a pending request and a half-full FIFO
    ack_en = 1'b0;
    send(CMD_START, 8'h00);
    send(CMD_SET_ADDR, 8'h00);
    send(CMD_SET_ADDR, 8'h50);
    send(CMD_SET_ADDR, 8'h00);
    for (int i = 0; i < 9; i++) send(CMD_DATA, 8'hC0 + 8'(i));
    check("t6_req_pending", {31'd0, bus.o_mem_req}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("t6");
    rst = 1'b0;
    force_tok++;
    repeat (3) @(negedge clk);
    check("t6_ack_ignored", {31'd0, bus.o_mem_req}, 32'd0);
    check("t6_loading", {31'd0, loading}, 32'd0);
    send(CMD_START, 8'h00);
    push_exp(22'h000000, 8'h99);
    send(CMD_DATA, 8'h99);
    send(CMD_END, 8'h00);
    ack_en = 1'b1;
    wait_done("t6_done");

    repeat (4) @(negedge clk);
    check("sb_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
